boot_rom_fetch: RTL
===================

# boot_rom_fetch

Instruction-side front end for the 1024×32 boot pROM, which has a two-cycle pipelined read and a synchronous output register. It accepts word fetch requests from the CPU instruction port on a valid/ready channel and drives the ROM's `ad`, `ce`, `oce` and `reset` pins. It tracks ROM read latency and returns data in order through a response FIFO that absorbs CPU backpressure. Range and alignment faults are flagged, and a flush drops stale fetches after a redirect.

## Interface
- `BASE_ADDR`, default `32'h0000_0000`: byte address of ROM word 0.
- `ADDR_WIDTH`, default `10`: ROM word-address width, giving 2^ADDR_WIDTH words.
- `FIFO_DEPTH`, default `4`: response FIFO entries and outstanding-request limit. Must be a power of 2 and at least 2. A value of 4 or more gives one fetch per cycle.
- `clk`, in, 1: single clock. All logic is clocked on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, 1: fetch request present.
- `req_ready`, out, 1: request accepted when both `req_valid` and `req_ready` are high.
- `req_addr`, in, 32: byte address of the fetch.
- `flush`, in, 1: discard all outstanding fetches.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: response consumed when both `rsp_valid` and `rsp_ready` are high.
- `rsp_data`, out, 32: instruction word, or 0 on fault.
- `rsp_err`, out, 1: fetch fault (out of range or misaligned).
- `rom_ad`, out, ADDR_WIDTH: ROM word address, equal to `req_addr[ADDR_WIDTH+1:2]` minus the BASE_ADDR offset. Combinational.
- `rom_ce`, out, 1: ROM clock enable. High only on an accepted, non-faulting request. Combinational.
- `rom_oce`, out, 1: ROM output-register enable. Tied to 1.
- `rom_reset`, out, 1: equal to `reset`.
- `rom_dout`, in, 32: ROM read data.

## Operation
- Fault rule: a request faults if `req_addr[1:0] != 0`, if `req_addr < BASE_ADDR`, or if `req_addr >= BASE_ADDR + 4*2^ADDR_WIDTH`.
  - A faulting request is still accepted, but `rom_ce` stays 0.
  - Its response carries `rsp_err=1` and `rsp_data=0`, with the same latency and position in order as a normal fetch.
- Pipeline: a two-stage shift register of {valid, err}.
  - Stage 1 loads at the accept edge.
  - Stage 2 advances from stage 1 at the following edge.
  - While stage 2 is valid, the edge after that pushes {`rom_dout` or 0, err} into the FIFO.
- Outstanding counter, range 0..FIFO_DEPTH.
  - Increments on accept and decrements on a response pop; both in one cycle leave it unchanged.
  - `req_ready = (outstanding < FIFO_DEPTH) & ~flush`.
  - `req_ready` has no combinational path from `rsp_ready`.
  - The counter guarantees FIFO space at every push, so overflow cannot occur.
- FIFO:
  - `rsp_valid` means the FIFO is not empty; `rsp_data` and `rsp_err` show the head entry, driven from registers.
  - A push into an empty FIFO and a simultaneous pop from a non-empty FIFO are both legal.
  - Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. A separate count or extra pointer bit distinguishes full from empty.
- Flush:
  - At the edge where `flush=1`, both pipeline valid bits and the FIFO are cleared and the outstanding counter resets to 0.
  - No request is accepted in a flush cycle.
  - A pop presented in a flush cycle is discarded, with no effect.
  - In-flight ROM data is ignored afterwards.
- Reset: asynchronously clears the pipeline, FIFO pointers and counter. Reset values:
  - `req_ready=1` and `rsp_valid=0`.
  - `rsp_data=0` and `rsp_err=0`.
  - `rom_ce=0`, `rom_oce=1`, `rom_reset=1`.
- Reset asserted mid-operation drops every outstanding fetch. No response is produced for any of them after release.

## Timing
- Latency: request accepted at edge E0 gives `rsp_valid=1` in the cycle after E2, i.e. 2 cycles from accept to response when the FIFO was empty.
- Timing of a read: the ROM registers the address at E0 and `rom_dout` is valid during the cycle after E1. That data is captured into the FIFO at E2.
- Throughput: with `rsp_ready` held high and FIFO_DEPTH=4, one response per cycle is sustained indefinitely. Steady-state outstanding count is 3.
- Backpressure: with `rsp_ready=0`, exactly FIFO_DEPTH requests are accepted before `req_ready` drops. It drops in the cycle after the FIFO_DEPTH-th accept.
- Recovery: `req_ready` returns high in the cycle after the first pop.
- Ordering: responses always emerge in acceptance order, including faulting ones.

## Test plan
- **Single fetch.** Preload word 5 = `32'h1303_0030`; request `req_addr=0x14` with `rsp_ready=1`.
  - `rom_ce=1` and `rom_ad=5` at accept.
  - `rsp_valid` asserts 2 cycles later with `rsp_data=0x1303_0030` and `rsp_err=0`.
- **Streaming.** Request addresses 0x00 through 0x3C back to back with `rsp_ready=1`.
  - 16 responses arrive on 16 consecutive cycles, in order, matching ROM words 0 to 15.
  - `req_ready` never drops.
- **Backpressure.** Hold `rsp_ready=0` and offer 6 requests.
  - Exactly 4 are accepted, then `req_ready=0`.
  - Raise `rsp_ready`: 4 in-order responses follow, and the remaining 2 requests are accepted after the first pop.
- **Faults.** Request `0x2` (misaligned) and `0x1000` (out of range, BASE=0), interleaved with `0x4`.
  - `rom_ce=0` for both faulting requests.
  - Responses in order: err=1/data=0, then the word-1 data with err=0, then err=1/data=0.
- **Flush.** Accept 3 requests, then pulse `flush` one cycle later.
  - No responses from those 3 ever appear.
  - A request in the cycle after the flush returns the correct data 2 cycles later.
- **Reset mid-operation.** With 3 requests outstanding and `rsp_ready=0`, assert `reset` asynchronously between edges.
  - Immediately: `rsp_valid=0`, `req_ready=1`, `rom_reset=1`.
  - After release: no stale responses, and a new fetch completes normally.

Source files
------------

// File: rtl/boot_rom_fetch_if.sv
// CPU instruction-port channel for the boot ROM fetch front end.
// Request: valid/ready with byte address, plus a redirect flush.
// Response: valid/ready with instruction word and fault flag.
interface boot_rom_fetch_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        flush;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;

    // CPU side drives requests and consumes responses
    modport master (
        output req_valid, req_addr, flush, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    // Fetch unit side accepts requests and produces responses
    modport slave (
        input  req_valid, req_addr, flush, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/boot_rom_fetch.sv
// Purpose: boot pROM fetch front end; drives ROM pins, tracks read latency, queues responses in order.
// Latency: accept at edge E0, response visible in the cycle after E2 (2 cycles into an empty FIFO).
// Backpressure: at most FIFO_DEPTH fetches outstanding; req_ready drops when the limit is reached or during flush.
module boot_rom_fetch #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          ADDR_WIDTH = 10,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    boot_rom_fetch_if.slave       cpu,
    output logic [ADDR_WIDTH-1:0] rom_ad,
    output logic                  rom_ce,
    output logic                  rom_oce,
    output logic                  rom_reset,
    input  logic [31:0]           rom_dout
);

    localparam int               PTR_W     = $clog2(FIFO_DEPTH);
    localparam int               CNT_W     = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [32:0]      ROM_BYTES = 33'd4 << ADDR_WIDTH;

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
    } rsp_t;

    logic [32:0]      off_ext;
    logic             fault;
    logic             accept;
    logic             push;
    logic             pop;
    rsp_t             push_ent;

    logic [CNT_W-1:0] outst_q,  outst_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             s1_vld_q, s1_err_q;
    logic             s2_vld_q, s2_err_q;
    rsp_t             mem_q [FIFO_DEPTH];

    // Offset from ROM base with a borrow bit: an address below the base
    // wraps to a value with bit 32 set, so one compare covers both bounds.
    assign off_ext = {1'b0, cpu.req_addr} - {1'b0, BASE_ADDR};
    assign fault   = (cpu.req_addr[1:0] != 2'b00) | (off_ext >= ROM_BYTES);

    // Request side: the ready term only looks at registered state and flush,
    // so it never depends combinationally on rsp_ready.
    assign cpu.req_ready = (outst_q < DEPTH_C) & ~cpu.flush;
    assign accept        = cpu.req_valid & cpu.req_ready;

    // ROM pins: faulting fetches still occupy a pipeline slot but never clock the ROM
    assign rom_ad    = off_ext[ADDR_WIDTH+1:2];
    assign rom_ce    = accept & ~fault;
    assign rom_oce   = 1'b1;
    assign rom_reset = reset;

    // Response side: head of the FIFO straight from registers
    assign cpu.rsp_valid = (cnt_q != '0);
    assign cpu.rsp_data  = mem_q[rd_ptr_q].dat;
    assign cpu.rsp_err   = mem_q[rd_ptr_q].err;

    assign pop          = cpu.rsp_valid & cpu.rsp_ready & ~cpu.flush;
    assign push         = s2_vld_q & ~cpu.flush;
    assign push_ent.err = s2_err_q;
    assign push_ent.dat = s2_err_q ? 32'h0 : rom_dout;

    // Next-state for the outstanding counter and FIFO pointers/count
    always_comb begin
        outst_d  = outst_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (cpu.flush) begin
            outst_d  = '0;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            unique case ({accept, pop})
                2'b10:   outst_d = outst_q + 1'b1;
                2'b01:   outst_d = outst_q - 1'b1;
                default: outst_d = outst_q;
            endcase
            unique case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Counter and pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outst_q  <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            outst_q  <= outst_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Two-stage {valid, err} shift register mirroring the ROM read pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s1_err_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s2_err_q <= 1'b0;
        end else begin
            s1_vld_q <= accept;
            s1_err_q <= fault;
            s2_vld_q <= s1_vld_q & ~cpu.flush;
            s2_err_q <= s1_err_q;
        end
    end

    // Response storage; cleared on reset so the head reads 0 out of reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= push_ent;
        end
    end

endmodule
